msx_bus_cycle_decoder: RTL and testbench

- Consumes the filtered, synchronised MSX slot signals produced by the cartridge bus input stage. Converts each Z80 memory or I/O read/write cycle into exactly one request on a valid/ready backend port.
- Returns read data and the drive and wait controls (DOUT, BUSDIR_n, WAIT_n) to that same input stage.
- Sits between the board bus stage and the cartridge function blocks (mappers, sound, SRAM).

---
 rtl/msx_bus_pkg.sv | 22 ++
 rtl/msx_bus_wait_timer.sv | 28 ++
 rtl/msx_bus_cycle_decoder.sv | 148 ++++++++++++++
 tb/tb_msx_bus_cycle_decoder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/msx_bus_pkg.sv
// Shared types for the MSX cartridge bus cycle decoder: FSM states, the latched
// backend request, and the value DOUT rests at whenever the bus is released.
package msx_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RESP,
        DRIVE,
        DONE
    } state_t;

    localparam logic [7:0] DOUT_IDLE = 8'hFF;

    typedef struct packed {
        logic        wr;
        logic        io;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } req_t;

endpackage

// File: rtl/msx_bus_wait_timer.sv
// Loadable saturating cycle counter; o_expire flags count == LIMIT-1, so a load
// followed by LIMIT enabled cycles spans exactly LIMIT cycles. No backpressure.
module msx_bus_wait_timer #(
    parameter int WIDTH = 7,
    parameter int LIMIT = 64
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = (r_count >= WIDTH'(LIMIT - 1));

endmodule

// File: rtl/msx_bus_cycle_decoder.sv
// Turns each qualified Z80 memory/I-O strobe into one valid/ready request; strobe->REQ_VALID 1 cycle,
// RSP_VALID->BUSDIR_n 1 cycle. REQ_VALID holds until REQ_READY; reads hold WAIT_n low meanwhile.
module msx_bus_cycle_decoder
    import msx_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter bit IO_ENABLE      = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic [15:0] ADDR,
    input  logic [7:0]  DIN,
    input  logic        SLTSL_n,
    input  logic        MERQ_n,
    input  logic        IORQ_n,
    input  logic        M1_n,
    input  logic        RFSH_n,
    input  logic        RD_n,
    input  logic        WR_n,
    output logic        REQ_VALID,
    input  logic        REQ_READY,
    output logic        REQ_WR,
    output logic        REQ_IO,
    output logic [15:0] REQ_ADDR,
    output logic [7:0]  REQ_WDATA,
    input  logic        RSP_VALID,
    input  logic        RSP_HIT,
    input  logic [7:0]  RSP_DATA,
    output logic [7:0]  DOUT,
    output logic        BUSDIR_n,
    output logic        WAIT_n,
    output logic        BUSY
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    state_t     r_state;
    req_t       r_req;
    logic       r_valid;
    logic       r_abort;
    logic       r_busdir_n;
    logic       r_wait_n;
    logic [7:0] r_dout;

    logic w_mem;
    logic w_io;
    logic w_strobe;
    logic w_accept;
    logic w_expire;

    assign w_mem    = !MERQ_n && !SLTSL_n && RFSH_n;
    assign w_io     = IO_ENABLE && !IORQ_n && M1_n;
    assign w_strobe = !RD_n || !WR_n;
    assign w_accept = r_valid && REQ_READY;

    msx_bus_wait_timer #(
        .WIDTH (TW),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .i_clk    (CLK),
        .i_rst_n  (RESET_n),
        .i_load   ((r_state == REQ) && w_accept),
        .i_en     (r_state == RESP),
        .o_expire (w_expire)
    );

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state    <= IDLE;
            r_req      <= '0;
            r_valid    <= 1'b0;
            r_abort    <= 1'b0;
            r_busdir_n <= 1'b1;
            r_wait_n   <= 1'b1;
            r_dout     <= DOUT_IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_strobe && (w_mem || w_io)) begin
                        r_req.wr   <= !WR_n;
                        r_req.io   <= !w_mem;
                        r_req.addr <= w_mem ? ADDR : {8'h00, ADDR[7:0]};
                        if (!WR_n) begin
                            r_req.wdata <= DIN;
                        end
                        r_valid  <= 1'b1;
                        r_abort  <= 1'b0;
                        r_wait_n <= !WR_n;
                        r_state  <= REQ;
                    end
                end
                REQ: begin
                    // A strobe that ends early frees the Z80 now; the request still has to drain.
                    if (!w_strobe) begin
                        r_abort  <= 1'b1;
                        r_wait_n <= 1'b1;
                    end
                    if (w_accept) begin
                        r_valid <= 1'b0;
                        if (r_req.wr || r_abort || !w_strobe) begin
                            r_wait_n <= 1'b1;
                            r_state  <= DONE;
                        end else begin
                            r_state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (w_strobe && RSP_VALID && RSP_HIT) begin
                        r_dout     <= RSP_DATA;
                        r_busdir_n <= 1'b0;
                        r_wait_n   <= 1'b1;
                        r_state    <= DRIVE;
                    end else if (!w_strobe || RSP_VALID || w_expire) begin
                        r_wait_n <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                DRIVE: begin
                    if (RD_n) begin
                        r_busdir_n <= 1'b1;
                        r_dout     <= DOUT_IDLE;
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    if (RD_n && WR_n) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign REQ_VALID = r_valid;
    assign REQ_WR    = r_req.wr;
    assign REQ_IO    = r_req.io;
    assign REQ_ADDR  = r_req.addr;
    assign REQ_WDATA = r_req.wdata;
    assign DOUT      = r_dout;
    assign BUSDIR_n  = r_busdir_n;
    assign WAIT_n    = r_wait_n;
    assign BUSY      = (r_state != IDLE);

endmodule

// File: tb/tb_msx_bus_cycle_decoder.sv
// Directed bench: expected requests are queued when a bus cycle is driven and matched at handshake.
module tb_msx_bus_cycle_decoder;

    localparam int TO = 64;

    logic        CLK = 1'b0;
    logic        RESET_n;
    logic [15:0] ADDR;
    logic [7:0]  DIN;
    logic        SLTSL_n, MERQ_n, IORQ_n, M1_n, RFSH_n, RD_n, WR_n;
    logic        REQ_READY, RSP_VALID, RSP_HIT;
    logic [7:0]  RSP_DATA;
    logic        REQ_VALID, REQ_WR, REQ_IO;
    logic [15:0] REQ_ADDR;
    logic [7:0]  REQ_WDATA, DOUT;
    logic        BUSDIR_n, WAIT_n, BUSY;

    logic        v2_valid, v2_wr, v2_io, v2_busdir_n, v2_wait_n, v2_busy;
    logic [15:0] v2_addr;
    logic [7:0]  v2_wdata, v2_dout;

    int          errors = 0;
    int          checks = 0;
    int          n_push = 0;
    int          n_acc  = 0;
    logic [25:0] exp_q[$];
    logic [25:0] e;
    logic        v2_seen = 1'b0;
    logic [7:0]  last_wdata = 8'h00;

    always #5 CLK = ~CLK;

    msx_bus_cycle_decoder #(.TIMEOUT_CYCLES(TO), .IO_ENABLE(1'b1)) dut (
        .CLK(CLK), .RESET_n(RESET_n), .ADDR(ADDR), .DIN(DIN), .SLTSL_n(SLTSL_n),
        .MERQ_n(MERQ_n), .IORQ_n(IORQ_n), .M1_n(M1_n), .RFSH_n(RFSH_n), .RD_n(RD_n),
        .WR_n(WR_n), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WR(REQ_WR),
        .REQ_IO(REQ_IO), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .RSP_VALID(RSP_VALID),
        .RSP_HIT(RSP_HIT), .RSP_DATA(RSP_DATA), .DOUT(DOUT), .BUSDIR_n(BUSDIR_n),
        .WAIT_n(WAIT_n), .BUSY(BUSY)
    );

    msx_bus_cycle_decoder #(.TIMEOUT_CYCLES(TO), .IO_ENABLE(1'b0)) dut_noio (
        .CLK(CLK), .RESET_n(RESET_n), .ADDR(ADDR), .DIN(DIN), .SLTSL_n(SLTSL_n),
        .MERQ_n(MERQ_n), .IORQ_n(IORQ_n), .M1_n(M1_n), .RFSH_n(RFSH_n), .RD_n(RD_n),
        .WR_n(WR_n), .REQ_VALID(v2_valid), .REQ_READY(REQ_READY), .REQ_WR(v2_wr),
        .REQ_IO(v2_io), .REQ_ADDR(v2_addr), .REQ_WDATA(v2_wdata), .RSP_VALID(RSP_VALID),
        .RSP_HIT(RSP_HIT), .RSP_DATA(RSP_DATA), .DOUT(v2_dout), .BUSDIR_n(v2_busdir_n),
        .WAIT_n(v2_wait_n), .BUSY(v2_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_idle();
        ADDR = 16'h0000; DIN = 8'h00;
        SLTSL_n = 1'b1; MERQ_n = 1'b1; IORQ_n = 1'b1; M1_n = 1'b1;
        RFSH_n = 1'b1; RD_n = 1'b1; WR_n = 1'b1;
    endtask

    task automatic push(input logic wr, input logic io, input logic [15:0] a, input logic [7:0] d);
        exp_q.push_back({wr, io, a, d});
        n_push++;
    endtask

    // Scoreboard: every accepted request must match the oldest queued expectation.
    always @(negedge CLK) begin
        if (RESET_n && REQ_VALID && REQ_READY) begin
            n_acc++;
            check("req_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("req_fields", 32'({REQ_WR, REQ_IO, REQ_ADDR, REQ_WDATA}), 32'(e));
            end
        end
        if (v2_valid) v2_seen = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic wait_low, bd, stable, done;
        int   wl, rc, a0;

        bus_idle();
        REQ_READY = 1'b1; RSP_VALID = 1'b0; RSP_HIT = 1'b0; RSP_DATA = 8'h00;
        RESET_n = 1'b0;
        repeat (3) tick();
        check("rst_valid",  32'(REQ_VALID), 32'd0);
        check("rst_wait",   32'(WAIT_n), 32'd1);
        check("rst_busdir", 32'(BUSDIR_n), 32'd1);
        check("rst_dout",   32'(DOUT), 32'hFF);
        check("rst_busy",   32'(BUSY), 32'd0);
        check("rst_req",    32'({REQ_WR, REQ_IO, REQ_ADDR, REQ_WDATA}), 32'd0);
        RESET_n = 1'b1;
        tick();

        // Memory write, long strobe
        push(1'b1, 1'b0, 16'h6000, 8'h05); last_wdata = 8'h05;
        SLTSL_n = 1'b0; MERQ_n = 1'b0; ADDR = 16'h6000; DIN = 8'h05; WR_n = 1'b0;
        wait_low = 1'b0;
        repeat (10) begin
            tick();
            if (!WAIT_n) wait_low = 1'b1;
        end
        bus_idle();
        tick(); tick();
        check("wr_wait_never_low", 32'(wait_low), 32'd0);
        check("wr_one_request", 32'(n_acc), 32'(n_push));

        // I/O read hit
        push(1'b0, 1'b1, 16'h00A0, last_wdata);
        IORQ_n = 1'b0; M1_n = 1'b1; ADDR = 16'h12A0; RD_n = 1'b0;
        wl = 0;
        repeat (5) begin
            tick();
            if (!WAIT_n) wl++;
        end
        RSP_VALID = 1'b1; RSP_HIT = 1'b1; RSP_DATA = 8'h3C;
        tick();
        RSP_VALID = 1'b0; RSP_HIT = 1'b0;
        check("io_wait_cycles", 32'(wl), 32'd5);
        check("io_busdir_drive", 32'(BUSDIR_n), 32'd0);
        check("io_dout", 32'(DOUT), 32'h3C);
        check("io_wait_release", 32'(WAIT_n), 32'd1);
        repeat (3) tick();
        check("io_drive_hold", 32'({BUSDIR_n, DOUT}), 32'({1'b0, 8'h3C}));
        RD_n = 1'b1; IORQ_n = 1'b1;
        tick();
        check("io_release", 32'({BUSDIR_n, DOUT}), 32'({1'b1, 8'hFF}));
        tick();
        check("io_idle", 32'(BUSY), 32'd0);

        // Memory read miss
        push(1'b0, 1'b0, 16'h4123, last_wdata);
        SLTSL_n = 1'b0; MERQ_n = 1'b0; ADDR = 16'h4123; RD_n = 1'b0;
        bd = 1'b0;
        repeat (4) begin
            tick();
            if (!BUSDIR_n) bd = 1'b1;
        end
        RSP_VALID = 1'b1; RSP_HIT = 1'b0; RSP_DATA = 8'h5A;
        tick();
        RSP_VALID = 1'b0;
        if (!BUSDIR_n) bd = 1'b1;
        check("miss_wait", 32'(WAIT_n), 32'd1);
        repeat (3) begin
            tick();
            if (!BUSDIR_n) bd = 1'b1;
        end
        check("miss_dout", 32'(DOUT), 32'hFF);
        bus_idle();
        tick(); tick();
        check("miss_never_driven", 32'(bd), 32'd0);

        // Memory read with no response
        push(1'b0, 1'b0, 16'h8001, last_wdata);
        SLTSL_n = 1'b0; MERQ_n = 1'b0; ADDR = 16'h8001; RD_n = 1'b0;
        rc = 0; done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            if (WAIT_n) done = 1'b1;
            else if (!REQ_VALID) rc++;
        end
        check("to_bound", 32'(done), 32'd1);
        check("to_cycles", 32'(rc), 32'(TO));
        check("to_bus", 32'({BUSDIR_n, DOUT}), 32'({1'b1, 8'hFF}));
        bus_idle();
        tick(); tick();

        // Qualification filters
        a0 = n_acc;
        SLTSL_n = 1'b0; MERQ_n = 1'b0; RFSH_n = 1'b0; RD_n = 1'b0; ADDR = 16'h1111;
        repeat (6) tick();
        bus_idle(); tick();
        check("filt_refresh", 32'(n_acc), 32'(a0));
        IORQ_n = 1'b0; M1_n = 1'b0; RD_n = 1'b0; ADDR = 16'h00FF;
        repeat (6) tick();
        bus_idle(); tick();
        check("filt_intack", 32'(n_acc), 32'(a0));
        SLTSL_n = 1'b1; MERQ_n = 1'b0; RD_n = 1'b0; ADDR = 16'h2222;
        repeat (6) tick();
        bus_idle(); tick();
        check("filt_slot", 32'(n_acc), 32'(a0));

        // I/O write: decoded by the main instance, ignored with I/O disabled
        v2_seen = 1'b0;
        push(1'b1, 1'b1, 16'h0033, 8'h77); last_wdata = 8'h77;
        IORQ_n = 1'b0; M1_n = 1'b1; ADDR = 16'hAB33; DIN = 8'h77; WR_n = 1'b0;
        repeat (4) tick();
        bus_idle();
        tick(); tick();
        check("noio_no_request", 32'(v2_seen), 32'd0);
        check("io_write_count", 32'(n_acc), 32'(n_push));

        // Backpressure with strobe abort
        REQ_READY = 1'b0;
        push(1'b0, 1'b0, 16'h5A5A, last_wdata);
        SLTSL_n = 1'b0; MERQ_n = 1'b0; ADDR = 16'h5A5A; RD_n = 1'b0;
        stable = 1'b1; bd = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (!REQ_VALID || ({REQ_WR, REQ_ADDR} !== {1'b0, 16'h5A5A})) stable = 1'b0;
            if (!BUSDIR_n) bd = 1'b1;
            if (i == 7) check("bp_wait_low", 32'(WAIT_n), 32'd0);
            if (i == 8) begin
                RD_n = 1'b1; SLTSL_n = 1'b1; MERQ_n = 1'b1; ADDR = 16'h0000;
            end
            if (i == 9) check("abort_wait", 32'(WAIT_n), 32'd1);
        end
        check("bp_stable", 32'(stable), 32'd1);
        check("bp_never_driven", 32'(bd), 32'd0);
        REQ_READY = 1'b1;
        tick(); tick();
        check("bp_idle", 32'(BUSY), 32'd0);
        check("bp_count", 32'(n_acc), 32'(n_push));

        // Asynchronous reset while driving
        push(1'b0, 1'b0, 16'h7000, last_wdata);
        SLTSL_n = 1'b0; MERQ_n = 1'b0; ADDR = 16'h7000; RD_n = 1'b0;
        tick(); tick();
        RSP_VALID = 1'b1; RSP_HIT = 1'b1; RSP_DATA = 8'h99;
        tick();
        RSP_VALID = 1'b0; RSP_HIT = 1'b0;
        check("rd_pre_drive", 32'({BUSDIR_n, DOUT}), 32'({1'b0, 8'h99}));
        #2 RESET_n = 1'b0;
        #1;
        check("arst_bus", 32'({BUSDIR_n, DOUT}), 32'({1'b1, 8'hFF}));
        check("arst_ctl", 32'({WAIT_n, REQ_VALID, BUSY}), 32'(3'b100));
        check("noio_rst_dat", {v2_addr, v2_wdata, v2_dout}, {16'h0000, 8'h00, 8'hFF});
        check("noio_rst_ctl", 32'({v2_wr, v2_io, v2_busdir_n, v2_wait_n, v2_busy}), 32'(5'b00110));
        bus_idle();
        tick();
        RESET_n = 1'b1;
        tick();

        push(1'b1, 1'b0, 16'h6001, 8'hA5); last_wdata = 8'hA5;
        SLTSL_n = 1'b0; MERQ_n = 1'b0; ADDR = 16'h6001; DIN = 8'hA5; WR_n = 1'b0;
        repeat (3) tick();
        bus_idle();
        repeat (3) tick();
        check("final_count", 32'(n_acc), 32'(n_push));
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
